// File: rtl/iob_reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding.
package iob_reset_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/iob_reset_seq_if.sv
// Control/status bundle of the reset sequencer; slave is the sequencer side.
interface iob_reset_seq_if #(
   parameter int N_STAGES = 3
);

   logic                cke_i;
   logic                sw_rst_i;
   logic [N_STAGES-1:0] rst_o;
   logic                done_o;

   modport master(output cke_i, output sw_rst_i, input rst_o, input done_o);
   modport slave(input cke_i, input sw_rst_i, output rst_o, output done_o);

endinterface

// File: rtl/iob_reg.sv
// Generic register with asynchronous active-high reset to RST_VAL and clock enable.
module iob_reg #(
   parameter int                DATA_W  = 1,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cke_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         data_o <= RST_VAL;
      end else if (cke_i) begin
         data_o <= data_i;
      end
   end

endmodule

// File: rtl/iob_reset_seq.sv
// Staged reset sequencer: holds all domain resets, then releases them in
// ascending order a fixed gap apart; software reset restarts the sequence.
module iob_reset_seq
   import iob_reset_seq_pkg::*;
#(
   parameter int N_STAGES    = 3,
   parameter int HOLD_W      = 8,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4
) (
   input logic            clk_i,
   input logic            arst_i,
   iob_reset_seq_if.slave bus
);

   localparam int                  STAGE_W    = $clog2(N_STAGES + 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   GAP_LAST   = HOLD_W'(STAGE_GAP - 1);
   localparam logic [STAGE_W-1:0]  STAGE_LAST = STAGE_W'(N_STAGES - 1);
   localparam logic [N_STAGES-1:0] ALL_ONES   = {N_STAGES{1'b1}};

   if (N_STAGES < 1 || HOLD_CYCLES < 1 || HOLD_CYCLES >= 2 ** HOLD_W ||
       STAGE_GAP < 1 || STAGE_GAP >= 2 ** HOLD_W) begin : g_param_check
      $error("iob_reset_seq: illegal N_STAGES/HOLD_CYCLES/STAGE_GAP for HOLD_W");
   end

   logic [STATE_W-1:0]  state_raw;
   state_t              state_q;
   state_t              state_nxt;
   logic [HOLD_W-1:0]   cnt_q;
   logic [HOLD_W-1:0]   cnt_nxt;
   logic [STAGE_W-1:0]  stage_q;
   logic [STAGE_W-1:0]  stage_nxt;
   logic [N_STAGES-1:0] rst_q;
   logic [N_STAGES-1:0] rst_nxt;
   logic                done_q;
   logic                done_nxt;

   assign state_q = state_t'(state_raw);

   // NOTE: every combinational output gets a default first, so no path
   // through the case can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      stage_nxt = stage_q;
      rst_nxt   = rst_q;
      done_nxt  = done_q;

      if (bus.sw_rst_i) begin
         state_nxt = HOLD;
         cnt_nxt   = '0;
         stage_nxt = '0;
         rst_nxt   = ALL_ONES;
         done_nxt  = 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_nxt[0] = 1'b0;
                  cnt_nxt    = '0;
                  stage_nxt  = STAGE_W'(1);
                  if (N_STAGES == 1) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = RELEASE;
                  end
               end else begin
                  cnt_nxt = cnt_q + HOLD_W'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  for (int i = 0; i < N_STAGES; i++) begin
                     if (stage_q == STAGE_W'(i)) rst_nxt[i] = 1'b0;
                  end
                  cnt_nxt   = '0;
                  stage_nxt = stage_q + STAGE_W'(1);
                  if (stage_q == STAGE_LAST) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt_q + HOLD_W'(1);
               end
            end
            DONE: begin
            end
            default: state_nxt = HOLD;
         endcase
      end
   end

   iob_reg #(.DATA_W(STATE_W), .RST_VAL(STATE_W'(HOLD))) u_state_reg (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (bus.cke_i),
      .data_i(state_nxt),
      .data_o(state_raw)
   );

   iob_reg #(.DATA_W(HOLD_W), .RST_VAL('0)) u_cnt_reg (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (bus.cke_i),
      .data_i(cnt_nxt),
      .data_o(cnt_q)
   );

   iob_reg #(.DATA_W(STAGE_W), .RST_VAL('0)) u_stage_reg (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (bus.cke_i),
      .data_i(stage_nxt),
      .data_o(stage_q)
   );

   iob_reg #(.DATA_W(N_STAGES), .RST_VAL(ALL_ONES)) u_rst_reg (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (bus.cke_i),
      .data_i(rst_nxt),
      .data_o(rst_q)
   );

   iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_done_reg (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .cke_i (bus.cke_i),
      .data_i(done_nxt),
      .data_o(done_q)
   );

   assign bus.rst_o  = rst_q;
   assign bus.done_o = done_q;

endmodule

// File: tb/tb_iob_reset_seq.sv
// Bench for iob_reset_seq: a default instance and a minimal N=1/H=1/G=1 instance,
// checked cycle by cycle against a release-time model through a scoreboard queue.
module tb_iob_reset_seq;

   logic clk;
   logic arst_a;
   logic arst_b;

   int total;
   int bad;

   // Edges counted since the last restart (arst or sampled sw_rst); frozen when cke=0.
   int n_a;
   int n_b;
   logic [3:0] q_a[$];
   logic [1:0] q_b[$];

   iob_reset_seq_if #(.N_STAGES(3)) bus_a ();
   iob_reset_seq_if #(.N_STAGES(1)) bus_b ();

   iob_reset_seq #(
      .N_STAGES(3), .HOLD_W(8), .HOLD_CYCLES(16), .STAGE_GAP(4)
   ) dut_a (
      .clk_i (clk),
      .arst_i(arst_a),
      .bus   (bus_a)
   );

   iob_reset_seq #(
      .N_STAGES(1), .HOLD_W(4), .HOLD_CYCLES(1), .STAGE_GAP(1)
   ) dut_b (
      .clk_i (clk),
      .arst_i(arst_b),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {rst_o, done_o}: bit i is held while n < HOLD + i*GAP.
   function automatic logic [3:0] model_a(input int n);
      logic [2:0] r;
      for (int i = 0; i < 3; i++) r[i] = (n < 16 + i * 4);
      return {r, (n >= 24)};
   endfunction

   function automatic logic [1:0] model_b(input int n);
      return {(n < 1), (n >= 1)};
   endfunction

   task automatic reset_a();
      bus_a.cke_i    = 1'b1;
      bus_a.sw_rst_i = 1'b0;
      @(negedge clk);
      arst_a = 1'b1;
      @(negedge clk);
      arst_a = 1'b0;
      n_a = 0;
      q_a.delete();
   endtask

   task automatic reset_b();
      bus_b.cke_i    = 1'b1;
      bus_b.sw_rst_i = 1'b0;
      @(negedge clk);
      arst_b = 1'b1;
      @(negedge clk);
      arst_b = 1'b0;
      n_b = 0;
      q_b.delete();
   endtask

   // Drive one edge of stimulus on instance A and push the model's expectation.
   task automatic step_a(input logic cke, input logic sw);
      bus_a.cke_i    = cke;
      bus_a.sw_rst_i = sw;
      @(posedge clk);
      if (cke) n_a = sw ? 0 : n_a + 1;
      q_a.push_back(model_a(n_a));
      @(negedge clk);
   endtask

   task automatic step_b(input logic cke, input logic sw);
      bus_b.cke_i    = cke;
      bus_b.sw_rst_i = sw;
      @(posedge clk);
      if (cke) n_b = sw ? 0 : n_b + 1;
      q_b.push_back(model_b(n_b));
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      reset_a();
      arst_a = 1'b1;
      #1;
      total++;
      if ({bus_a.rst_o, bus_a.done_o} !== 4'b1110) begin
         bad++;
         $display("FAIL reset_state_a got=%b want=1110", {bus_a.rst_o, bus_a.done_o});
      end
      total++;
      if ({bus_b.rst_o, bus_b.done_o} !== 2'b10) begin
         bad++;
         $display("FAIL reset_state_b got=%b want=10", {bus_b.rst_o, bus_b.done_o});
      end
      reset_a();
      for (int e = 1; e <= 3; e++) begin
         step_a(1'b1, 1'b0);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL reset_hold edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
      end
   endtask

   task automatic test_release();
      logic [3:0] exp;
      int r0_edge;
      int done_edge;
      r0_edge   = -1;
      done_edge = -1;
      reset_a();
      for (int e = 1; e <= 40; e++) begin
         step_a(1'b1, 1'b0);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL release edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
         if (r0_edge < 0 && bus_a.rst_o[0] === 1'b0) r0_edge = e;
         if (done_edge < 0 && bus_a.done_o === 1'b1) done_edge = e;
      end
      total++;
      if (r0_edge != 16) begin
         bad++;
         $display("FAIL release_stage0_edge got=%0d want=16", r0_edge);
      end
      total++;
      if (done_edge != 24) begin
         bad++;
         $display("FAIL release_done_edge got=%0d want=24", done_edge);
      end
   endtask

   task automatic test_sw_rst_done();
      logic [3:0] exp;
      int r0_edge;
      int done_edge;
      r0_edge   = -1;
      done_edge = -1;
      reset_a();
      for (int e = 1; e <= 60; e++) begin
         step_a(1'b1, e == 30);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL sw_rst_done edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
         if (e > 30 && r0_edge < 0 && bus_a.rst_o[0] === 1'b0) r0_edge = e;
         if (e > 30 && done_edge < 0 && bus_a.done_o === 1'b1) done_edge = e;
      end
      total++;
      if (r0_edge != 46) begin
         bad++;
         $display("FAIL sw_rst_stage0_edge got=%0d want=46", r0_edge);
      end
      total++;
      if (done_edge != 54) begin
         bad++;
         $display("FAIL sw_rst_done_edge got=%0d want=54", done_edge);
      end
   endtask

   task automatic test_sw_collision();
      logic [3:0] exp;
      int r0_edge;
      r0_edge = -1;
      reset_a();
      for (int e = 1; e <= 45; e++) begin
         step_a(1'b1, e == 20);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL sw_collision edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
         if (e == 20) begin
            total++;
            if (bus_a.rst_o !== 3'b111) begin
               bad++;
               $display("FAIL sw_collision_priority got=%b want=111", bus_a.rst_o);
            end
         end
         if (e > 20 && r0_edge < 0 && bus_a.rst_o[0] === 1'b0) r0_edge = e;
      end
      total++;
      if (r0_edge != 36) begin
         bad++;
         $display("FAIL sw_collision_stage0_edge got=%0d want=36", r0_edge);
      end
   endtask

   task automatic test_back_to_back_sw();
      logic [3:0] exp;
      reset_a();
      for (int e = 1; e <= 40; e++) begin
         step_a(1'b1, e <= 10);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL sw_held edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
      end
   endtask

   task automatic test_cke_freeze();
      logic [3:0] exp;
      int r0_edge;
      int done_edge;
      r0_edge   = -1;
      done_edge = -1;
      reset_a();
      for (int e = 1; e <= 35; e++) begin
         step_a(!(e >= 10 && e <= 14), e == 12);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL cke_freeze edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
         if (r0_edge < 0 && bus_a.rst_o[0] === 1'b0) r0_edge = e;
         if (done_edge < 0 && bus_a.done_o === 1'b1) done_edge = e;
      end
      total++;
      if (r0_edge != 21) begin
         bad++;
         $display("FAIL cke_stage0_edge got=%0d want=21", r0_edge);
      end
      total++;
      if (done_edge != 29) begin
         bad++;
         $display("FAIL cke_done_edge got=%0d want=29", done_edge);
      end
   endtask

   task automatic test_async_mid();
      logic [3:0] exp;
      reset_a();
      for (int e = 1; e <= 22; e++) begin
         step_a(1'b1, 1'b0);
         void'(q_a.pop_front());
      end
      #2 arst_a = 1'b1;
      #1;
      total++;
      if ({bus_a.rst_o, bus_a.done_o} !== 4'b1110) begin
         bad++;
         $display("FAIL async_mid_a got=%b want=1110", {bus_a.rst_o, bus_a.done_o});
      end
      reset_a();
      for (int e = 1; e <= 18; e++) begin
         step_a(1'b1, 1'b0);
         exp = q_a.pop_front();
         total++;
         if ({bus_a.rst_o, bus_a.done_o} !== exp) begin
            bad++;
            $display("FAIL async_restart edge=%0d got=%b want=%b", e, {bus_a.rst_o, bus_a.done_o}, exp);
         end
      end
   endtask

   task automatic test_small_config();
      logic [1:0] exp;
      reset_b();
      for (int e = 1; e <= 6; e++) begin
         step_b(1'b1, e == 3);
         exp = q_b.pop_front();
         total++;
         if ({bus_b.rst_o, bus_b.done_o} !== exp) begin
            bad++;
            $display("FAIL small_cfg edge=%0d got=%b want=%b", e, {bus_b.rst_o, bus_b.done_o}, exp);
         end
         if (e == 1) begin
            total++;
            if ({bus_b.rst_o, bus_b.done_o} !== 2'b01) begin
               bad++;
               $display("FAIL small_cfg_edge1 got=%b want=01", {bus_b.rst_o, bus_b.done_o});
            end
         end
      end
      #2 arst_b = 1'b1;
      #1;
      total++;
      if ({bus_b.rst_o, bus_b.done_o} !== 2'b10) begin
         bad++;
         $display("FAIL small_cfg_async got=%b want=10", {bus_b.rst_o, bus_b.done_o});
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      n_a            = 0;
      n_b            = 0;
      arst_a         = 1'b1;
      arst_b         = 1'b1;
      bus_a.cke_i    = 1'b1;
      bus_a.sw_rst_i = 1'b0;
      bus_b.cke_i    = 1'b1;
      bus_b.sw_rst_i = 1'b0;

      test_reset();
      test_release();
      test_sw_rst_done();
      test_sw_collision();
      test_back_to_back_sw();
      test_cke_freeze();
      test_async_mid();
      test_small_config();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
